// File: rtl/itch_pkg.sv
// ============================================================================
// Module      : itch_pkg
// Description : Shared types and constants for the ITCH message dispatcher.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package itch_pkg;

    localparam int TRACKER_W    = 6;
    localparam int WORD_W       = 64;
    localparam int TYPE_TABLE_N = 8;

    // Parser i serves TYPE_CODE[i]; codes are unique so the lookup stays one-hot.
    localparam logic [7:0] TYPE_CODE [TYPE_TABLE_N] = '{
        8'h4F,  // 'O' order book state
        8'h41,  // 'A' add order
        8'h45,  // 'E' order executed
        8'h58,  // 'X' order cancel
        8'h44,  // 'D' order delete
        8'h55,  // 'U' order replace
        8'h46,  // 'F' add order with attribution
        8'h43   // 'C' executed with price
    };

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ALIGN = 2'd1,
        S_BUSY  = 2'd2,
        S_ABORT = 2'd3
    } state_t;

endpackage

`default_nettype wire

// File: rtl/itch_type_lookup.sv
// ============================================================================
// Module      : itch_type_lookup
// Description : Combinational type byte to {hit, one-hot parser index}.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module itch_type_lookup
    import itch_pkg::*;
#(
    parameter int NUM_PARSERS = 4    // must not exceed TYPE_TABLE_N
) (
    input  logic [7:0]             type_byte,
    output logic                   hit,
    output logic [NUM_PARSERS-1:0] sel_onehot
);

    always_comb begin
        sel_onehot = '0;
        for (int i = 0; i < NUM_PARSERS; i++) begin
            if (type_byte == TYPE_CODE[i]) begin
                sel_onehot[i] = 1'b1;
            end
        end
    end

    assign hit = |sel_onehot;

endmodule

`default_nettype wire

// File: rtl/itch_msg_dispatcher.sv
// ============================================================================
// Module      : itch_msg_dispatcher
// Description : Finds each ITCH message type byte in the 64-bit stream and
//               enables the matching field parser until it reports its end.
//               Optional ITCH_DISPATCH_STATS_EN adds msg/err counters.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module itch_msg_dispatcher
    import itch_pkg::*;
#(
    parameter int NUM_PARSERS = 4,
    parameter int MAX_WORDS   = 8
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [WORD_W-1:0]                data_in,
    input  logic                             data_valid,
    output logic                             data_ready,
    output logic [NUM_PARSERS-1:0]           parser_en,
    output logic [TRACKER_W-1:0]             parser_tracker,
    input  logic [NUM_PARSERS-1:0]           parser_end,
    input  logic [TRACKER_W*NUM_PARSERS-1:0] parser_next,
    output logic [7:0]                       msg_type,
    output logic                             busy,
    output logic                             err_unknown,
    output logic                             err_timeout
`ifdef ITCH_DISPATCH_STATS_EN
    ,
    output logic [32*NUM_PARSERS-1:0]        msg_count,
    output logic [15:0]                      err_count
`endif
);

    localparam int CNT_W = $clog2(MAX_WORDS + 2);

    state_t                 state_q, state_d;
    logic [TRACKER_W-1:0]   tracker_q, tracker_d;
    logic [TRACKER_W-1:0]   ptrk_q, ptrk_d;
    logic [TRACKER_W-1:0]   next_sel;
    logic [NUM_PARSERS-1:0] sel_q, sel_d;
    logic [NUM_PARSERS-1:0] hit_vec, en_c;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   last_q, last_d;
    logic [7:0]             msg_type_q, msg_type_d;
    logic [7:0]             type_byte;
    logic                   hit, end_sel, accept_end;
    logic                   err_unk_c, err_to_c, ready_c;

    assign type_byte = data_in[tracker_q +: 8];

    itch_type_lookup #(
        .NUM_PARSERS (NUM_PARSERS)
    ) u_lookup (
        .type_byte  (type_byte),
        .hit        (hit),
        .sel_onehot (hit_vec)
    );

    always_comb begin
        end_sel  = |(parser_end & sel_q);
        next_sel = '0;
        for (int i = 0; i < NUM_PARSERS; i++) begin
            if (sel_q[i]) begin
                next_sel = parser_next[i*TRACKER_W +: TRACKER_W];
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        tracker_d  = tracker_q;
        ptrk_d     = ptrk_q;
        sel_d      = sel_q;
        cnt_d      = cnt_q;
        last_d     = last_q;
        msg_type_d = msg_type_q;
        en_c       = '0;
        err_unk_c  = 1'b0;
        err_to_c   = 1'b0;
        ready_c    = 1'b1;
        accept_end = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (data_valid) begin
                    msg_type_d = type_byte;
                    if (hit) begin
                        sel_d = hit_vec;
                        if (tracker_q == TRACKER_W'(56)) begin
                            state_d = S_ALIGN;
                        end else begin
                            en_c    = hit_vec;
                            ptrk_d  = tracker_q + TRACKER_W'(8);
                            cnt_d   = CNT_W'(1);
                            last_d  = 1'b0;
                            state_d = S_BUSY;
                        end
                    end else begin
                        // Unknown type: the rest of the word is untrustworthy, resync at byte 0.
                        err_unk_c = 1'b1;
                        tracker_d = '0;
                    end
                end
            end

            S_ALIGN: begin
                if (data_valid) begin
                    en_c    = sel_q;
                    ptrk_d  = '0;
                    cnt_d   = CNT_W'(1);
                    last_d  = 1'b0;
                    state_d = S_BUSY;
                end
            end

            S_BUSY: begin
                if (data_valid) begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (last_q) begin
                        en_c    = sel_q;
                        last_d  = 1'b0;
                        state_d = S_IDLE;
                    end else if (end_sel) begin
                        // End beats a coincident timeout; parser still needs its last word.
                        en_c       = sel_q;
                        tracker_d  = next_sel;
                        last_d     = 1'b1;
                        accept_end = 1'b1;
                    end else if (cnt_q == CNT_W'(MAX_WORDS)) begin
                        err_to_c = 1'b1;
                        state_d  = S_ABORT;
                    end else begin
                        en_c = sel_q;
                    end
                end
            end

            S_ABORT: begin
                ready_c   = 1'b0;
                tracker_d = '0;
                state_d   = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            tracker_q  <= '0;
            ptrk_q     <= '0;
            sel_q      <= '0;
            cnt_q      <= '0;
            last_q     <= 1'b0;
            msg_type_q <= '0;
        end else begin
            state_q    <= state_d;
            tracker_q  <= tracker_d;
            ptrk_q     <= ptrk_d;
            sel_q      <= sel_d;
            cnt_q      <= cnt_d;
            last_q     <= last_d;
            msg_type_q <= msg_type_d;
        end
    end

    // Combinational outputs are masked while rst is held so nothing leaks to the parsers.
    assign parser_en      = rst ? '0   : en_c;
    assign parser_tracker = rst ? '0   : ptrk_d;
    assign err_unknown    = rst ? 1'b0 : err_unk_c;
    assign err_timeout    = rst ? 1'b0 : err_to_c;
    assign data_ready     = rst ? 1'b1 : ready_c;
    assign msg_type       = msg_type_q;
    assign busy           = (state_q != S_IDLE);

`ifdef ITCH_DISPATCH_STATS_EN
    logic [32*NUM_PARSERS-1:0] msg_count_q, msg_count_d;
    logic [15:0]               err_count_q, err_count_d;

    always_comb begin
        msg_count_d = msg_count_q;
        err_count_d = err_count_q;
        for (int i = 0; i < NUM_PARSERS; i++) begin
            if (accept_end && sel_q[i]) begin
                msg_count_d[i*32 +: 32] = msg_count_q[i*32 +: 32] + 32'd1;
            end
        end
        if ((err_unk_c || err_to_c) && (err_count_q != 16'hFFFF)) begin
            err_count_d = err_count_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            msg_count_q <= '0;
            err_count_q <= '0;
        end else begin
            msg_count_q <= msg_count_d;
            err_count_q <= err_count_d;
        end
    end

    assign msg_count = msg_count_q;
    assign err_count = err_count_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_itch_msg_dispatcher.sv
// ============================================================================
// Module      : tb_itch_msg_dispatcher
// Description : Vector-table bench for itch_msg_dispatcher with an expectation queue.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_itch_msg_dispatcher;

    localparam int NP = 4;
    localparam logic [7:0] T_O = 8'h4F;
    localparam logic [7:0] T_A = 8'h41;
    localparam logic [7:0] T_E = 8'h45;
    localparam logic [7:0] T_X = 8'h58;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [63:0]    data_in = '0;
    logic           data_valid = 1'b0;
    logic           data_ready;
    logic [NP-1:0]  parser_en;
    logic [5:0]     parser_tracker;
    logic [NP-1:0]  parser_end = '0;
    logic [6*NP-1:0] parser_next = '0;
    logic [7:0]     msg_type;
    logic           busy;
    logic           err_unknown;
    logic           err_timeout;
`ifdef ITCH_DISPATCH_STATS_EN
    logic [32*NP-1:0] msg_count;
    logic [15:0]      err_count;
`endif

    itch_msg_dispatcher #(
        .NUM_PARSERS (NP),
        .MAX_WORDS   (8)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .data_in        (data_in),
        .data_valid     (data_valid),
        .data_ready     (data_ready),
        .parser_en      (parser_en),
        .parser_tracker (parser_tracker),
        .parser_end     (parser_end),
        .parser_next    (parser_next),
        .msg_type       (msg_type),
        .busy           (busy),
        .err_unknown    (err_unknown),
        .err_timeout    (err_timeout)
`ifdef ITCH_DISPATCH_STATS_EN
        ,
        .msg_count      (msg_count),
        .err_count      (err_count)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        r;
        logic        v;
        logic [63:0] d;
        logic [3:0]  pe;
        logic [23:0] pn;
        logic [3:0]  en;
        int          ptrk;   // -1: not compared
        logic        unk;
        logic        to;
        logic        busy;
        logic        rdy;
        logic [7:0]  mt;
    } vec_t;

    vec_t vecs[$];
    vec_t expq[$];
    int   errors = 0;
    int   checks = 0;
    int   split;

    function automatic logic [63:0] wd(input int b, input logic [7:0] v);
        logic [63:0] w;
        w = '0;
        w[b*8 +: 8] = v;
        return w;
    endfunction

    // Non-selected slots carry 8 so a wrong slot pick shows up as a wrong offset.
    function automatic logic [23:0] pn(input int s, input logic [5:0] v);
        logic [23:0] p;
        p = {4{6'd8}};
        p[s*6 +: 6] = v;
        return p;
    endfunction

    function automatic void add(input logic r, input logic v, input logic [63:0] d,
                                input logic [3:0] pe, input logic [23:0] pnx,
                                input logic [3:0] en, input int ptrk, input logic unk,
                                input logic to, input logic bsy, input logic rdy,
                                input logic [7:0] mt);
        vec_t t;
        t.r = r; t.v = v; t.d = d; t.pe = pe; t.pn = pnx;
        t.en = en; t.ptrk = ptrk; t.unk = unk; t.to = to;
        t.busy = bsy; t.rdy = rdy; t.mt = mt;
        vecs.push_back(t);
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic apply(input vec_t t, input int idx);
        vec_t e;
        rst         = t.r;
        data_valid  = t.v;
        data_in     = t.d;
        parser_end  = t.pe;
        parser_next = t.pn;
        expq.push_back(t);
        @(negedge clk);
        e = expq.pop_front();
        chk($sformatf("v%0d parser_en", idx), 64'(parser_en), 64'(e.en));
        if (e.ptrk >= 0)
            chk($sformatf("v%0d parser_tracker", idx), 64'(parser_tracker), 64'(e.ptrk));
        chk($sformatf("v%0d err_unknown", idx), 64'(err_unknown), 64'(e.unk));
        chk($sformatf("v%0d err_timeout", idx), 64'(err_timeout), 64'(e.to));
        chk($sformatf("v%0d busy", idx), 64'(busy), 64'(e.busy));
        chk($sformatf("v%0d data_ready", idx), 64'(data_ready), 64'(e.rdy));
        chk($sformatf("v%0d msg_type", idx), 64'(msg_type), 64'(e.mt));
        @(posedge clk);
        #1;
    endtask

    initial begin
        // reset state
        add(1, 0, 64'd0, 4'd0, 24'd0, 4'b0000, 0, 0, 0, 0, 1, 8'h00);
        add(1, 0, 64'd0, 4'd0, 24'd0, 4'b0000, 0, 0, 0, 0, 1, 8'h00);
        // 'O' at byte 0: same-cycle enable, end with next=40, one extra word
        add(0, 1, wd(0, T_O), 4'd0, 24'd0, 4'b0001, 8, 0, 0, 0, 1, 8'h00);
        add(0, 1, 64'd0, 4'b0001, pn(0, 6'd40), 4'b0001, 8, 0, 0, 1, 1, T_O);
        add(0, 1, 64'd0, 4'd0, 24'd0, 4'b0001, 8, 0, 0, 1, 1, T_O);
        // next lookup at byte 5; non-selected end ignored; end next=56
        add(0, 1, wd(5, T_A) | wd(0, T_O), 4'd0, 24'd0, 4'b0010, 48, 0, 0, 0, 1, T_O);
        add(0, 1, 64'd0, 4'b0001, pn(0, 6'd8), 4'b0010, 48, 0, 0, 1, 1, T_A);
        add(0, 1, 64'd0, 4'b0010, pn(1, 6'd56), 4'b0010, 48, 0, 0, 1, 1, T_A);
        add(0, 1, 64'd0, 4'd0, 24'd0, 4'b0010, 48, 0, 0, 1, 1, T_A);
        // type in bits 63:56: body starts next valid word at offset 0
        add(0, 1, wd(7, T_O) | wd(0, T_A), 4'd0, 24'd0, 4'b0000, -1, 0, 0, 0, 1, T_A);
        add(0, 0, wd(0, T_A), 4'd0, 24'd0, 4'b0000, -1, 0, 0, 1, 1, T_O);
        add(0, 1, wd(0, T_A), 4'd0, 24'd0, 4'b0001, 0, 0, 0, 1, 1, T_O);
        add(0, 1, 64'd0, 4'b0001, pn(0, 6'd16), 4'b0001, 0, 0, 0, 1, 1, T_O);
        add(0, 1, 64'd0, 4'd0, 24'd0, 4'b0001, 0, 0, 0, 1, 1, T_O);
        // unknown type at byte 2, then resync at byte 0
        add(0, 1, wd(2, 8'hFF) | wd(0, T_O), 4'd0, 24'd0, 4'b0000, -1, 1, 0, 0, 1, T_O);
        add(0, 1, wd(0, T_E) | wd(2, T_O), 4'd0, 24'd0, 4'b0100, 8, 0, 0, 0, 1, 8'hFF);
        add(0, 1, 64'd0, 4'd0, 24'd0, 4'b0100, 8, 0, 0, 1, 1, T_E);
        // 3-cycle stall: ends during stall are not taken, count frozen
        for (int i = 0; i < 3; i++)
            add(0, 0, 64'd0, 4'b0100, pn(2, 6'd40), 4'b0000, -1, 0, 0, 1, 1, T_E);
        for (int i = 0; i < 6; i++)
            add(0, 1, 64'd0, 4'd0, 24'd0, 4'b0100, 8, 0, 0, 1, 1, T_E);
        // 8 words delivered with no end: timeout, abort cycle, back to idle
        add(0, 1, 64'd0, 4'd0, 24'd0, 4'b0000, -1, 0, 1, 1, 1, T_E);
        add(0, 1, wd(0, T_O), 4'd0, 24'd0, 4'b0000, -1, 0, 0, 1, 0, T_E);
        add(0, 1, wd(0, T_X), 4'd0, 24'd0, 4'b1000, 8, 0, 0, 0, 1, T_E);
        for (int i = 0; i < 7; i++)
            add(0, 1, 64'd0, 4'd0, 24'd0, 4'b1000, 8, 0, 0, 1, 1, T_X);
        // end on the same cycle as the timeout limit: end wins
        add(0, 1, 64'd0, 4'b1000, pn(3, 6'd24), 4'b1000, 8, 0, 0, 1, 1, T_X);
        add(0, 1, 64'd0, 4'd0, 24'd0, 4'b1000, 8, 0, 0, 1, 1, T_X);
        add(0, 1, wd(3, T_O), 4'd0, 24'd0, 4'b0001, 32, 0, 0, 0, 1, T_X);
        add(0, 1, 64'd0, 4'd0, 24'd0, 4'b0001, 32, 0, 0, 1, 1, T_O);
        split = vecs.size();
        // reset mid-message: enable drops, in-flight end discarded
        add(1, 1, wd(0, T_O), 4'b0001, pn(0, 6'd40), 4'b0000, 0, 0, 0, 1, 1, T_O);
        add(1, 1, wd(0, T_O), 4'b0001, pn(0, 6'd40), 4'b0000, 0, 0, 0, 0, 1, 8'h00);
        add(0, 1, wd(5, T_A) | wd(0, T_O), 4'd0, 24'd0, 4'b0001, 8, 0, 0, 0, 1, 8'h00);
        add(0, 1, 64'd0, 4'd0, 24'd0, 4'b0001, 8, 0, 0, 1, 1, T_O);

        rst = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < split; i++)
            apply(vecs[i], i);

`ifdef ITCH_DISPATCH_STATS_EN
        chk("err_count", 64'(err_count), 64'd2);
        chk("msg_count0", 64'(msg_count[31:0]), 64'd2);
        chk("msg_count1", 64'(msg_count[63:32]), 64'd1);
        chk("msg_count2", 64'(msg_count[95:64]), 64'd0);
        chk("msg_count3", 64'(msg_count[127:96]), 64'd1);
`endif

        for (int i = split; i < vecs.size(); i++)
            apply(vecs[i], i);

`ifdef ITCH_DISPATCH_STATS_EN
        chk("err_count after rst", 64'(err_count), 64'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
